// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - SRAM-like data-bus responder with in-order programmable-latency responses
// Optional feature macro: SRAM_RAND_DELAY_EN (LFSR-gated accepts and 0..3 extra response cycles).
module sram_like_responder #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [2:0]  outst_cnt
);

  // Queue storage is sized for the largest legal MAX_OUTST so 2-bit pointers index it exactly;
  // only the first MAX_OUTST slots are ever used.
  localparam int QD = 4;

  logic [31:0]       mem [2**ADDR_W];
  logic              q_wr   [QD];
  logic [31:0]       q_data [QD];
  logic [3:0]        q_cnt  [QD];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic              accept;
  logic              retire;
  logic              gate;
  logic [3:0]        load_cnt;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  // Upper address bits alias and the byte offset is ignored; size carries no shaping here.
  assign idx         = addr[ADDR_W+1:2];
  assign unused_bits = ^{addr[31:ADDR_W+2], addr[1:0], size};

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16/14/13/11, free-running; drives accept gating and extra latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign gate     = lfsr[0];
  assign load_cnt = 4'(LATENCY - 1) + {2'b00, lfsr[2:1]};
`else
  assign gate     = 1'b1;
  assign load_cnt = 4'(LATENCY - 1);
`endif

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(MAX_OUTST - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Accept uses the registered count only, so a same-cycle retire never frees a slot early.
  always_comb begin
    addr_ok = resetn & req & gate & (outst_cnt < 3'(MAX_OUTST));
    accept  = req & addr_ok;
    retire  = (outst_cnt != 3'd0) && (q_cnt[rd_ptr] == 4'd0);
  end

  // Memory write at the handshake edge, per enabled byte lane; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Response FIFO: capture on accept, count down every slot, retire the head when its count hits zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      outst_cnt <= 3'd0;
      data_ok   <= 1'b0;
      rdata     <= 32'd0;
      for (int i = 0; i < QD; i++) begin
        q_wr[i]   <= 1'b0;
        q_data[i] <= 32'd0;
        q_cnt[i]  <= 4'd0;
      end
    end else begin
      data_ok <= retire;
      if (retire) begin
        rdata  <= q_wr[rd_ptr] ? 32'd0 : q_data[rd_ptr];
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (accept) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      case ({accept, retire})
        2'b10:   outst_cnt <= outst_cnt + 3'd1;
        2'b01:   outst_cnt <= outst_cnt - 3'd1;
        default: outst_cnt <= outst_cnt;
      endcase
      for (int i = 0; i < QD; i++) begin
        if (accept && (wr_ptr == 2'(i))) begin
          q_wr[i]   <= wr;
          q_data[i] <= wr ? 32'd0 : mem[idx];
          q_cnt[i]  <= load_cnt;
        end else if (q_cnt[i] != 4'd0) begin
          q_cnt[i] <= q_cnt[i] - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb/tb_sram_like_responder.sv - self-checking scoreboard bench for sram_like_responder
module tb_sram_like_responder;

  localparam int LAT = 2;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        req    = 1'b0;
  logic        req_b  = 1'b0;
  logic        wr     = 1'b0;
  logic [1:0]  size   = 2'd2;
  logic [31:0] addr   = 32'd0;
  logic [3:0]  wstrb  = 4'd0;
  logic [31:0] wdata  = 32'd0;
  logic        addr_ok, data_ok, addr_ok_b, data_ok_b;
  logic [31:0] rdata, rdata_b;
  logic [2:0]  outst_cnt, outst_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [1024];

  sram_like_responder #(.ADDR_W(10), .LATENCY(LAT), .MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .outst_cnt(outst_cnt)
  );

  sram_like_responder #(.ADDR_W(10), .LATENCY(4), .MAX_OUTST(2)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
    .rdata(rdata_b), .outst_cnt(outst_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pop the oldest expectation on every data_ok and compare data and timing.
  always @(negedge clk) begin
    exp_t e;
    if (data_ok) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_data_ok: got data_ok=1 rdata=%h, required no response", rdata);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.data) begin
          errors++;
          $display("FAIL rdata: got %h, required %h", rdata, e.data);
        end
        checks++;
`ifdef SRAM_RAND_DELAY_EN
        if (cyc < e.due || cyc > e.due + 3 + 2 * LAT + 8) begin
          errors++;
          $display("FAIL latency: got response cycle %0d, required %0d..%0d", cyc, e.due, e.due + 3 + 2 * LAT + 8);
        end
`else
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: got response cycle %0d, required %0d", cyc, e.due);
        end
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_t       e;
    int         n;
    logic [9:0] i;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = d;
    n     = 0;
    #1;
    while (!addr_ok && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!addr_ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: got addr_ok=0 for %0d cycles, required a handshake", n);
    end else begin
      i = a[11:2];
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
        end
        e.data = 32'd0;
      end else begin
        e.data = model[i];
      end
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses missing, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req    = 1'b1;
    req_b  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b, required 0", addr_ok); end
    checks++;
    if (addr_ok_b !== 1'b0) begin errors++; $display("FAIL reset_addr_ok_b: got %b, required 0", addr_ok_b); end
    checks++;
    if (outst_cnt !== 3'd0) begin errors++; $display("FAIL reset_outst: got %0d, required 0", outst_cnt); end
    checks++;
    if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b, required 0", data_ok); end
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    req    = 1'b0;
    req_b  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    drain();
  endtask

  task automatic test_partial_strobe();
    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20, 4'b0100, 32'h00AA0000);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    drain();
  endtask

  task automatic test_alias();
    issue(1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A);
    issue(1'b0, 32'h0000, 4'h0, 32'h0);
    issue(1'b0, 32'h0003, 4'h0, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int k = 0; k < 16; k++) begin
      a = $urandom();
      a[11:2] = 10'(k);
      issue(1'b1, a, 4'hF, $urandom());
    end
    for (int k = 0; k < 200; k++) begin
      a = $urandom();
      a[11:2] = 10'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
  endtask

  task automatic test_full_stall();
`ifndef SRAM_RAND_DELAY_EN
    logic [7:0] ok_pat;
    logic [7:0] dok_pat;
    int         out_pat [8];
    ok_pat  = 8'b0110_0011;
    dok_pat = 8'b0110_0000;
    out_pat = '{0, 1, 2, 2, 2, 1, 1, 2};
    wr      = 1'b0;
    addr    = 32'h40;
    req_b   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (addr_ok_b !== ok_pat[k]) begin
        errors++;
        $display("FAIL stall_addr_ok[%0d]: got %b, required %b", k, addr_ok_b, ok_pat[k]);
      end
      checks++;
      if (outst_b !== 3'(out_pat[k])) begin
        errors++;
        $display("FAIL stall_outst[%0d]: got %0d, required %0d", k, outst_b, out_pat[k]);
      end
      checks++;
      if (data_ok_b !== dok_pat[k]) begin
        errors++;
        $display("FAIL stall_data_ok[%0d]: got %b, required %b", k, data_ok_b, dok_pat[k]);
      end
      @(negedge clk);
    end
    req_b = 1'b0;
    repeat (12) @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    resetn = 1'b0;
    req    = 1'b1;
    #1;
    checks++;
    if (addr_ok !== 1'b0) begin errors++; $display("FAIL midreset_addr_ok: got %b, required 0", addr_ok); end
    sb.delete();
    @(negedge clk);
    #1;
    checks++;
    if (outst_cnt !== 3'd0) begin errors++; $display("FAIL midreset_outst: got %0d, required 0", outst_cnt); end
    resetn = 1'b1;
    req    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (data_ok !== 1'b0) begin errors++; $display("FAIL midreset_data_ok[%0d]: got %b, required 0", k, data_ok); end
    end
    @(negedge clk);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_alias();
    test_back_to_back();
    test_full_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
